// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared constants, FSM state encoding and config-word helper
// for the convolution command sequencer.
package conv_seq_pkg;

   // Command codes presented on the controller's control port.
   localparam logic [1:0] CTRL_CFG = 2'b00;
   localparam logic [1:0] CTRL_KER = 2'b01;
   localparam logic [1:0] CTRL_IMG = 2'b10;
   localparam logic [1:0] CTRL_RUN = 2'b11;

   localparam int unsigned MAX_ELEMS = 256;   // controller address space in elements
   localparam int unsigned ELEM_W    = 9;     // holds 0..MAX_ELEMS
   localparam int unsigned DATA_W    = 32;    // one stream element
   localparam int unsigned BEAT_W    = 128;   // one command payload beat

   // Config-word field offsets (8-bit fields).
   localparam int unsigned CFGW_M0 = 0;
   localparam int unsigned CFGW_M1 = 8;
   localparam int unsigned CFGW_S  = 16;
   localparam int unsigned CFGW_L0 = 24;
   localparam int unsigned CFGW_L1 = 32;

   typedef enum logic [2:0] {
      IDLE, CFG, FILL_K, SEND_K, FILL_I, SEND_I, RUN, FIN
   } seq_state_e;

   // Config word: kernel side twice (M, N=M), stride, image side twice (L, W=L).
   function automatic logic [BEAT_W-1:0] pack_cfg(input logic [7:0] m,
                                                  input logic [7:0] s,
                                                  input logic [7:0] l);
      logic [BEAT_W-1:0] w;
      w = '0;
      w[CFGW_M0 +: 8] = m;
      w[CFGW_M1 +: 8] = m;
      w[CFGW_S  +: 8] = s;
      w[CFGW_L0 +: 8] = l;
      w[CFGW_L1 +: 8] = l;
      return w;
   endfunction

endpackage

// File: rtl/conv_beat_fifo.sv
// conv_beat_fifo: single-clock FIFO of 128-bit beats with show-ahead head.
// Ports: clk, rst (async active-low), flush (drop all contents), push/push_data,
//        pop, head_c (current head, combinational), count, full_c, empty_c.
module conv_beat_fifo
   import conv_seq_pkg::*;
#(
   parameter int unsigned DEPTH = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          push,
   input  logic [BEAT_W-1:0]             push_data,
   input  logic                          pop,
   output logic [BEAT_W-1:0]             head_c,
   output logic [$clog2(DEPTH+1)-1:0]    count,
   output logic                          full_c,
   output logic                          empty_c
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [BEAT_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic              do_push, do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full_c  = (count == CW'(DEPTH));
   assign empty_c = (count == '0);
   assign head_c  = mem[rd_ptr];
   assign do_push = push && !full_c;
   assign do_pop  = pop && !empty_c;

   // Storage needs no reset: occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/conv_cmd_sequencer.sv
// conv_cmd_sequencer: drives the convolution controller's control/Datain
// command interface. Buffers the kernel, then the image, as 4-element beats
// and emits each phase as a gap-free burst, then issues the run phase.
// Ports: clk, rst (async active-low), start + cfg_m/cfg_s/cfg_l (config),
//        s_valid/s_data/s_ready (element stream), control/Datain (commands),
//        busy, done (end-of-sequence pulse), cfg_error (sticky reject flag).
// Build option: CONV_SEQ_ABORT_EN adds the abort input (return to IDLE).
module conv_cmd_sequencer
   import conv_seq_pkg::*;
#(
   parameter int unsigned DEPTH_BEATS = 64,
   parameter int unsigned CNT_W       = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        cfg_m,
   input  logic [7:0]        cfg_s,
   input  logic [7:0]        cfg_l,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic [1:0]        control,
   output logic [BEAT_W-1:0] Datain,
   output logic              busy,
   output logic              done,
   output logic              cfg_error
`ifdef CONV_SEQ_ABORT_EN
   ,
   input  logic              abort
`endif
);
   localparam int unsigned FCW = $clog2(DEPTH_BEATS + 1);

   seq_state_e        state_q, state_d;
   logic [1:0]        control_d;
   logic [BEAT_W-1:0] datain_d, cfg_word_q, cfg_word_d, pack_q, pack_d, merged;
   logic              s_ready_d, busy_d, done_d, cfg_error_d;
   logic [ELEM_W-1:0] mm_q, mm_d, ll_q, ll_d, kb_q, kb_d, ib_q, ib_d, elem_q, elem_d;
   logic [ELEM_W-1:0] phase_elems, phase_beats;
   logic [CNT_W-1:0]  run_cyc_q, run_cyc_d, cyc_q, cyc_d;
   logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
   logic [BEAT_W-1:0] fifo_head;
   logic [FCW-1:0]    fifo_count;
   logic [31:0]       m32, s32, l32, mm32, ll32, ib32, o32, count_next;
   logic              cfg_ok, accept, abort_req;

`ifdef CONV_SEQ_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   conv_beat_fifo #(.DEPTH(DEPTH_BEATS)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (fifo_flush),
      .push      (fifo_push),
      .push_data (merged),
      .pop       (fifo_pop),
      .head_c    (fifo_head),
      .count     (fifo_count),
      .full_c    (fifo_full),
      .empty_c   (fifo_empty)
   );

   // Derived sizes and legality of the config presented with start.
   always_comb begin
      m32    = 32'(cfg_m);
      s32    = 32'(cfg_s);
      l32    = 32'(cfg_l);
      mm32   = m32 * m32;
      ll32   = l32 * l32;
      ib32   = (ll32 + 32'd3) >> 2;
      o32    = (s32 == 32'd0 || m32 > l32) ? 32'd0 : (l32 - m32) / s32 + 32'd1;
      cfg_ok = (m32 != 32'd0) && (s32 != 32'd0) && (m32 <= l32) &&
               (ll32 <= MAX_ELEMS) && (ib32 <= DEPTH_BEATS);
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      control_d   = control;
      datain_d    = Datain;
      s_ready_d   = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      cfg_error_d = cfg_error;
      cfg_word_d  = cfg_word_q;
      mm_d        = mm_q;
      ll_d        = ll_q;
      kb_d        = kb_q;
      ib_d        = ib_q;
      run_cyc_d   = run_cyc_q;
      elem_d      = elem_q;
      cyc_d       = cyc_q;
      pack_d      = pack_q;
      fifo_push   = 1'b0;
      fifo_pop    = 1'b0;
      fifo_flush  = 1'b0;

      accept      = s_valid && s_ready && !fifo_full;
      phase_elems = (state_q == FILL_K) ? mm_q : ll_q;
      phase_beats = (state_q inside {FILL_K, SEND_K}) ? kb_q : ib_q;
      // Partial beat with the incoming element dropped into its lane.
      merged      = pack_q;
      merged[{elem_q[1:0], 5'd0} +: DATA_W] = s_data;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  state_d     = CFG;
                  cfg_word_d  = pack_cfg(cfg_m, cfg_s, cfg_l);
                  datain_d    = pack_cfg(cfg_m, cfg_s, cfg_l);
                  control_d   = CTRL_CFG;
                  cfg_error_d = 1'b0;
                  mm_d        = ELEM_W'(mm32);
                  ll_d        = ELEM_W'(ll32);
                  kb_d        = ELEM_W'((mm32 + 32'd3) >> 2);
                  ib_d        = ELEM_W'(ib32);
                  run_cyc_d   = CNT_W'(32'd1 + o32 * o32 * mm32);
                  cyc_d       = '0;
                  elem_d      = '0;
                  pack_d      = '0;
               end else begin
                  cfg_error_d = 1'b1;
                  done_d      = 1'b1;
               end
            end
         end
         CFG: begin
            // Two neutral cycles let the controller's size registers settle.
            if (cyc_q == CNT_W'(1)) begin
               state_d = FILL_K;
               cyc_d   = '0;
            end else begin
               cyc_d = cyc_q + CNT_W'(1);
            end
         end
         FILL_K, FILL_I: begin
            if (accept) begin
               elem_d = elem_q + ELEM_W'(1);
               if (elem_q[1:0] == 2'd3 || elem_d == phase_elems) begin
                  fifo_push = 1'b1;
                  pack_d    = '0;
               end else begin
                  pack_d = merged;
               end
            end
            // Whole phase buffered: first beat goes out on the next edge.
            if (32'(fifo_count) == 32'(phase_beats)) begin
               state_d   = (state_q == FILL_K) ? SEND_K : SEND_I;
               control_d = (state_q == FILL_K) ? CTRL_KER : CTRL_IMG;
               datain_d  = fifo_head;
               fifo_pop  = 1'b1;
               cyc_d     = CNT_W'(1);
               elem_d    = '0;
            end
         end
         SEND_K, SEND_I: begin
            // cyc_q counts beats already loaded into Datain.
            if (cyc_q < CNT_W'(phase_beats)) begin
               datain_d = fifo_head;
               fifo_pop = !fifo_empty;
               cyc_d    = cyc_q + CNT_W'(1);
            end else if (state_q == SEND_K) begin
               state_d   = FILL_I;
               control_d = CTRL_CFG;
               datain_d  = cfg_word_q;
               cyc_d     = '0;
            end else begin
               state_d   = RUN;
               control_d = CTRL_RUN;
               datain_d  = '0;
               cyc_d     = CNT_W'(1);
            end
         end
         RUN: begin
            if (cyc_q < run_cyc_q) begin
               cyc_d = cyc_q + CNT_W'(1);
            end else begin
               state_d   = FIN;
               control_d = CTRL_CFG;
               datain_d  = cfg_word_q;
               done_d    = 1'b1;
               cyc_d     = '0;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort wins over any transition taken above.
      if (abort_req && state_q != IDLE) begin
         state_d    = IDLE;
         control_d  = CTRL_CFG;
         datain_d   = cfg_word_q;
         done_d     = 1'b0;
         cyc_d      = '0;
         elem_d     = '0;
         pack_d     = '0;
         fifo_push  = 1'b0;
         fifo_pop   = 1'b0;
         fifo_flush = 1'b1;
      end

      busy_d     = (state_d != IDLE);
      count_next = 32'(fifo_count) + 32'(fifo_push) - 32'(fifo_pop);
      s_ready_d  = ((state_d == FILL_K && elem_d < mm_d) ||
                    (state_d == FILL_I && elem_d < ll_d)) &&
                   (count_next < DEPTH_BEATS);
   end

   // State, registered outputs and sequence bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         control    <= CTRL_CFG;
         Datain     <= '0;
         s_ready    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cfg_error  <= 1'b0;
         cfg_word_q <= '0;
         mm_q       <= '0;
         ll_q       <= '0;
         kb_q       <= '0;
         ib_q       <= '0;
         run_cyc_q  <= '0;
         elem_q     <= '0;
         cyc_q      <= '0;
         pack_q     <= '0;
      end else begin
         state_q    <= state_d;
         control    <= control_d;
         Datain     <= datain_d;
         s_ready    <= s_ready_d;
         busy       <= busy_d;
         done       <= done_d;
         cfg_error  <= cfg_error_d;
         cfg_word_q <= cfg_word_d;
         mm_q       <= mm_d;
         ll_q       <= ll_d;
         kb_q       <= kb_d;
         ib_q       <= ib_d;
         run_cyc_q  <= run_cyc_d;
         elem_q     <= elem_d;
         cyc_q      <= cyc_d;
         pack_q     <= pack_d;
      end
   end

endmodule

// File: tb/tb_conv_cmd_sequencer.sv
// tb_conv_cmd_sequencer: self-checking bench for conv_cmd_sequencer. A
// reference model derives beat contents, burst lengths and run length from
// the configuration; the observed command trace is checked against it.
module tb_conv_cmd_sequencer;
   logic         clk = 1'b0;
   logic         rst, start, s_valid, s_ready, busy, done, cfg_error;
   logic [7:0]   cfg_m, cfg_s, cfg_l;
   logic [31:0]  s_data;
   logic [1:0]   control;
   logic [127:0] Datain;
`ifdef CONV_SEQ_ABORT_EN
   logic         abort;
`endif
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   conv_cmd_sequencer #(.DEPTH_BEATS(64), .CNT_W(20)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .cfg_m     (cfg_m),
      .cfg_s     (cfg_s),
      .cfg_l     (cfg_l),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .control   (control),
      .Datain    (Datain),
      .busy      (busy),
      .done      (done),
      .cfg_error (cfg_error)
`ifdef CONV_SEQ_ABORT_EN
      ,
      .abort     (abort)
`endif
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full sequence. intr: 0 none, 1 reset mid image burst, 2 abort in run.
   task automatic run_seq(input int m, input int s, input int l, input bit stall,
                          input bit seq_vals, input int intr, input bit try_start);
      logic [31:0]  st[$];
      logic [127:0] kb_exp[$], ib_exp[$];
      logic [127:0] beat, cfgw;
      int nk, ni, kb, ib, o, run_cyc, idx, c;
      int k_n, k_first, k_last, i_n, i_first, i_last, r_n, r_first, r_last;
      int done_c, k_acc_c, i_acc_c;
      bit acc_pend, bad_run, bad_ready, bad_cfg;

      nk = m * m;  ni = l * l;
      kb = (nk + 3) / 4;  ib = (ni + 3) / 4;
      o = (l - m) / s + 1;
      run_cyc = 1 + o * o * m * m;
      for (int e = 0; e < nk; e++) st.push_back(seq_vals ? 32'(e + 1) : $urandom);
      for (int e = 0; e < ni; e++) st.push_back(seq_vals ? 32'(e + 1) : $urandom);
      for (int b = 0; b < kb; b++) begin
         beat = '0;
         for (int j = 0; j < 4; j++) if (4 * b + j < nk) beat[32 * j +: 32] = st[4 * b + j];
         kb_exp.push_back(beat);
      end
      for (int b = 0; b < ib; b++) begin
         beat = '0;
         for (int j = 0; j < 4; j++) if (4 * b + j < ni) beat[32 * j +: 32] = st[nk + 4 * b + j];
         ib_exp.push_back(beat);
      end
      cfgw = '0;
      cfgw[39:0] = {8'(l), 8'(l), 8'(s), 8'(m), 8'(m)};

      k_n = 0; i_n = 0; r_n = 0;
      k_first = -1; k_last = -1; i_first = -1; i_last = -1; r_first = -1; r_last = -1;
      done_c = -1; k_acc_c = -1; i_acc_c = -1;
      acc_pend = 0; bad_run = 0; bad_ready = 0; bad_cfg = 0;
      idx = 0; c = 0;

      @(negedge clk);
      cfg_m = 8'(m); cfg_s = 8'(s); cfg_l = 8'(l); start = 1'b1;
      while (done_c < 0 && c < 30000) begin
         @(negedge clk);
         start = 1'b0;
         if (acc_pend) idx++;
         if (idx == nk && k_acc_c < 0) k_acc_c = c;
         if (idx == nk + ni && i_acc_c < 0) i_acc_c = c;
         if (c < 2 && (control !== 2'b00 || Datain !== cfgw || s_ready !== 1'b0)) bad_cfg = 1;
         case (control)
            2'b01: begin
               if (k_n < kb) check("ker_beat", Datain, kb_exp[k_n]);
               if (k_first < 0) k_first = c;
               k_last = c; k_n++;
            end
            2'b10: begin
               if (i_n < ib) check("img_beat", Datain, ib_exp[i_n]);
               if (i_first < 0) i_first = c;
               i_last = c; i_n++;
            end
            2'b11: begin
               if (Datain !== '0) bad_run = 1;
               if (r_first < 0) r_first = c;
               r_last = c; r_n++;
            end
            default: ;
         endcase
         if (control != 2'b00 && s_ready) bad_ready = 1;
         if (done) done_c = c;

         if (intr == 1 && control == 2'b10 && i_n == 2) begin
            rst = 1'b0;
            #1;
            check("rst_control", control, 0);
            check("rst_datain", Datain, 0);
            check("rst_s_ready", s_ready, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_cfg_error", cfg_error, 0);
            s_valid = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            return;
         end
`ifdef CONV_SEQ_ABORT_EN
         if (intr == 2 && control == 2'b11 && r_n == 3) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("abort_control", control, 0);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_fifo_empty", u_dut.u_fifo.empty_c, 1);
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               if (done) done_c = c;
            end
            check("abort_no_done", done_c < 0, 1);
            return;
         end
`endif
         s_valid = stall ? c[0] : ($urandom_range(3) != 0);
         s_data  = (idx < nk + ni) ? st[idx] : $urandom;
         acc_pend = s_valid && s_ready;
         if (try_start) begin
            start = (c == 3);
            cfg_m = (c == 3) ? 8'd0 : 8'(m);
         end
         c++;
      end
      s_valid = 1'b0;

      check("done_seen", done_c >= 0, 1);
      check("cfg_phase", bad_cfg, 0);
      check("ker_count", k_n, kb);
      check("ker_contig", k_last - k_first, kb - 1);
      check("ker_after_fill", k_acc_c >= 0 && k_first > k_acc_c, 1);
      check("img_count", i_n, ib);
      check("img_contig", i_last - i_first, ib - 1);
      check("img_after_fill", i_acc_c >= 0 && i_first > i_acc_c && i_first > k_last, 1);
      check("run_count", r_n, run_cyc);
      check("run_follows_img", r_first, i_last + 1);
      check("run_contig", r_last - r_first, run_cyc - 1);
      check("run_datain_zero", bad_run, 0);
      check("done_after_run", done_c, r_last + 1);
      check("ready_outside_fill", bad_ready, 0);
      check("elems_consumed", idx, nk + ni);
      check("cfg_error_clear", cfg_error, 0);
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_control", control, 0);
      check("idle_datain", Datain, cfgw);
   endtask

   // Illegal config: error flag and done next cycle, nothing else issued.
   task automatic err_cfg(input int m, input int s, input int l, input string tag);
      @(negedge clk);
      cfg_m = 8'(m); cfg_s = 8'(s); cfg_l = 8'(l); start = 1'b1; s_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_cfg_error"}, cfg_error, 1);
      check({tag, "_done"}, done, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_control"}, control, 0);
      check({tag, "_s_ready"}, s_ready, 0);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_sticky"}, cfg_error, 1);
      check({tag, "_control2"}, control, 0);
      check({tag, "_s_ready2"}, s_ready, 0);
      s_valid = 1'b0;
   endtask

   initial begin
      int m, s, l;
      rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
      cfg_m = '0; cfg_s = '0; cfg_l = '0;
`ifdef CONV_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("reset_control", control, 0);
      check("reset_datain", Datain, 0);
      check("reset_s_ready", s_ready, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_cfg_error", cfg_error, 0);
      rst = 1'b1;
      @(negedge clk);

      run_seq(3, 1, 5, 1'b0, 1'b1, 0, 1'b0);
      run_seq(2, 2, 4, 1'b0, 1'b0, 0, 1'b0);
      err_cfg(6, 1, 5, "m_gt_l");
      err_cfg(3, 0, 5, "s_zero");
      err_cfg(3, 1, 17, "l_big");
      run_seq(3, 1, 5, 1'b1, 1'b0, 0, 1'b1);
      run_seq(3, 1, 5, 1'b0, 1'b0, 1, 1'b0);
      run_seq(3, 1, 5, 1'b0, 1'b0, 0, 1'b0);
      run_seq(1, 1, 16, 1'b0, 1'b0, 0, 1'b0);
      run_seq(16, 5, 16, 1'b1, 1'b0, 0, 1'b0);
`ifdef CONV_SEQ_ABORT_EN
      run_seq(2, 1, 6, 1'b0, 1'b0, 2, 1'b0);
      run_seq(2, 1, 4, 1'b0, 1'b0, 0, 1'b0);
`endif
      for (int t = 0; t < 4; t++) begin
         m = int'($urandom_range(6, 1));
         l = int'($urandom_range(16, m));
         s = int'($urandom_range(3, 1));
         run_seq(m, s, l, 1'($urandom_range(1)), 1'b0, 0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
